axil_master_bridge: RTL
=======================

// Module: axil_master_bridge
// PURPOSE
//  Converts the core's single-request load/store port into AXI4-Lite master transactions.
//  It is the initiator end of the AXI4-Lite fabric and drives slaves such as the CLINT and the UART.
//  At most one transaction is outstanding at a time; responses return in order.
//  AXI response codes are folded into a single error flag.
// PARAMETERS
//  ADDR_W   32   address width (request port and AxADDR)
//  DATA_W   32   data width; STRB_W = DATA_W/8 (local)
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  req_valid    in   1        core request valid
//  req_ready    out  1        bridge can accept a request (comb: state==IDLE)
//  req_write    in   1        1=store, 0=load
//  req_addr     in   ADDR_W   byte address
//  req_wdata    in   DATA_W   store data
//  req_wstrb    in   STRB_W   store byte enables
//  rsp_valid    out  1        response valid (registered)
//  rsp_ready    in   1        core accepts response
//  rsp_rdata    out  DATA_W   load data; 0 for stores
//  rsp_err      out  1        1 if xRESP was SLVERR/DECERR
//  m_awaddr/m_awvalid/m_awready   out/out/in  ADDR_W/1/1   AW channel
//  m_wdata/m_wstrb/m_wvalid/m_wready out/out/out/in DATA_W/STRB_W/1/1  W channel
//  m_bresp/m_bvalid/m_bready      in/in/out   2/1/1        B channel
//  m_araddr/m_arvalid/m_arready   out/out/in  ADDR_W/1/1   AR channel
//  m_rdata/m_rresp/m_rvalid/m_rready in/in/in/out DATA_W/2/1/1  R channel
// BEHAVIOUR
//  Reset values:
//   - All valid/ready outputs (m_*valid, m_bready, m_rready, rsp_valid) are 0.
//   - Address, data, strobe, rsp_rdata and rsp_err outputs are 0.
//   - State is IDLE.
//  Mid-operation reset: the pending transaction is abandoned; the fabric is reset together with the bridge.
//  States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//  IDLE, on req_valid (req_ready=1):
//   - Register address, data and strobe.
//   - store -> WR_REQ with m_awvalid=m_wvalid=1 from the next cycle.
//   - load -> RD_REQ with m_arvalid=1 from the next cycle.
//  WR_REQ:
//   - Each of awvalid and wvalid drops the cycle after its own handshake.
//   - AW and W may complete in either order or in the same cycle.
//   - The transaction is never re-issued.
//   - Once both have completed -> WR_RESP with m_bready=1.
//  WR_RESP, on m_bvalid:
//   - rsp_err <= (bresp!=2'b00); rsp_rdata <= 0; m_bready <= 0.
//   - rsp_valid <= 1; go to RSP.
//  RD_REQ, on m_arready: m_arvalid <= 0, m_rready <= 1; go to RD_RESP.
//  RD_RESP, on m_rvalid:
//   - Capture m_rdata; rsp_err <= (rresp!=2'b00); m_rready <= 0.
//   - rsp_valid <= 1; go to RSP.
//  RSP:
//   - Hold rsp_valid/rdata/err stable until rsp_ready, then rsp_valid <= 0 and go to IDLE.
//   - No AXI valid is asserted while in RSP.
//  AXI rules:
//   - Valid signals never drop before their handshake.
//   - Payload is stable while valid is high.
//   - Valid never depends combinationally on a slave ready.
//  EXOKAY (2'b01) is treated as an error; AXI4-Lite slaves never return it.
//  Latency: a zero-wait slave gives accept@0, AW/W or AR handshake@1, B/R@2, rsp_valid@3.
//   - Next req_ready is the cycle after rsp_ready.
//  req_* inputs are ignored outside IDLE.
// STRUCTURE
//  Shared package axi_pkg:
//   - axi_resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
//   - Also reused by the slaves.
//  The bridge state enum stays local.
//  Single flat module; no sub-module is warranted.
// TESTING
//  1. Store 0x4000/0x00001234/strb 0xF, slave awready=wready=1.
//     -> One AW and one W handshake in the same cycle; bresp OKAY; rsp_valid with rsp_err=0.
//  2. Store with W ready 3 cycles after AW.
//     -> awvalid low after its handshake, wvalid held 3 cycles; exactly one AW and one W; bready only afterwards.
//  3. Load 0xBFF8, slave returns 0xDEADBEEF/OKAY after 2 wait cycles.
//     -> rsp_rdata=0xDEADBEEF, rsp_err=0, arvalid held through the wait cycles.
//  4. Load with rresp=SLVERR, then store with bresp=DECERR.
//     -> rsp_err=1 on both responses.
//  5. rsp_ready low 5 cycles with req_valid high.
//     -> rsp_valid and rsp_rdata stable, req_ready=0, no AXI valid asserted; accept resumes after rsp_ready.
//  6. rst_n asserted in WR_REQ with awvalid high.
//     -> All valids 0 immediately; after release, req_ready=1 and a new load completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite definitions, used by the master bridge and by the fabric slaves.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  // Anything but OKAY is an error; a Lite slave should never send EXOKAY.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Core load/store port to AXI4-Lite master; one transaction outstanding at a time,
// every AXI output registered so no valid depends combinationally on a slave ready.
module axil_master_bridge
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic                awvalid_reg, awvalid_next;
  logic                wvalid_reg, wvalid_next;
  logic                bready_reg, bready_next;
  logic                arvalid_reg, arvalid_next;
  logic                rready_reg, rready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                aw_done, w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    // A channel counts as done once its valid is already low or handshakes now.
    aw_done        = !awvalid_reg || m_awready;
    w_done         = !wvalid_reg || m_wready;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next  = req_addr;
          wdata_next = req_wdata;
          wstrb_next = req_wstrb;
          if (req_write) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            state_next   = WR_REQ;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_reg && m_awready) awvalid_next = 1'b0;
        if (wvalid_reg && m_wready)   wvalid_next  = 1'b0;
        if (aw_done && w_done) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          rsp_err_next   = resp_is_err(m_bresp);
          rsp_rdata_next = '0;
          bready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end
      RD_REQ: begin
        if (m_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_rvalid) begin
          rsp_rdata_next = m_rdata;
          rsp_err_next   = resp_is_err(m_rresp);
          rready_next    = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign m_awaddr  = addr_reg;
  assign m_awvalid = awvalid_reg;
  assign m_wdata   = wdata_reg;
  assign m_wstrb   = wstrb_reg;
  assign m_wvalid  = wvalid_reg;
  assign m_bready  = bready_reg;
  assign m_araddr  = addr_reg;
  assign m_arvalid = arvalid_reg;
  assign m_rready  = rready_reg;

endmodule
